// File: rtl/alarm_countdown_timer.sv
// Seconds countdown for the alarm controller: loads on a start_timer rising edge,
// counts down on a 1 Hz timebase, and raises expired at zero.
module alarm_countdown_timer #(
   parameter int CLK_HZ = 100_000_000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start_timer,
   input  logic [3:0] value,
   output logic       expired,
   output logic       one_hz_enable,
   output logic       half_hz_enable,
   output logic [3:0] value_display
);

   localparam int PW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(CLK_HZ - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_COUNT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t        r_state;
   logic [PW-1:0] r_prescaler;
   logic [3:0]    r_remaining;
   logic          r_start_prev;
   logic          r_expired;
   logic          r_half_hz;
   logic [3:0]    r_display;

   logic          w_start;
   logic          w_one_hz;

   assign w_start  = start_timer & ~r_start_prev;
   assign w_one_hz = (r_prescaler == PRE_MAX);

   assign expired        = r_expired;
   assign one_hz_enable  = w_one_hz;
   assign half_hz_enable = r_half_hz;
   assign value_display  = r_display;

   // Timebase: a load realigns the prescaler so the first second is a full one
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_prescaler <= '0;
         r_half_hz   <= 1'b0;
      end else begin
         if (w_start || w_one_hz) begin
            r_prescaler <= '0;
         end else begin
            r_prescaler <= r_prescaler + {{(PW-1){1'b0}}, 1'b1};
         end
         if (w_one_hz) begin
            r_half_hz <= ~r_half_hz;
         end else begin
            r_half_hz <= r_half_hz;
         end
      end
   end

   // Countdown FSM; a load takes priority over a coincident decrement
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state      <= S_IDLE;
         r_remaining  <= 4'd0;
         r_start_prev <= 1'b0;
         r_expired    <= 1'b0;
         r_display    <= 4'd0;
      end else begin
         r_start_prev <= start_timer;
         if (w_start) begin
            r_remaining <= value;
            r_display   <= value;
            if (value == 4'd0) begin
               r_state   <= S_DONE;
               r_expired <= 1'b1;
            end else begin
               r_state   <= S_COUNT;
               r_expired <= 1'b0;
            end
         end else begin
            case (r_state)
               S_IDLE: begin
                  r_display <= value;
                  r_expired <= 1'b0;
               end
               S_COUNT: begin
                  if (w_one_hz && (r_remaining != 4'd0)) begin
                     r_remaining <= r_remaining - 4'd1;
                     r_display   <= r_remaining - 4'd1;
                     if (r_remaining == 4'd1) begin
                        r_state   <= S_DONE;
                        r_expired <= 1'b1;
                     end else begin
                        r_state   <= S_COUNT;
                        r_expired <= 1'b0;
                     end
                  end else begin
                     r_remaining <= r_remaining;
                  end
               end
               S_DONE: begin
                  r_expired <= 1'b1;
                  r_display <= 4'd0;
               end
               default: begin
                  r_state     <= S_IDLE;
                  r_remaining <= 4'd0;
                  r_expired   <= 1'b0;
                  r_display   <= 4'd0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_alarm_countdown_timer.sv
// Self-checking bench for alarm_countdown_timer at CLK_HZ=4: a vector table for
// reset/timebase behaviour plus load sequences checked through a scoreboard queue.
module tb_alarm_countdown_timer;

   localparam int CLK_HZ = 4;

   logic       clock = 1'b0;
   logic       reset;
   logic       start_timer;
   logic [3:0] value;
   logic       expired;
   logic       one_hz_enable;
   logic       half_hz_enable;
   logic [3:0] value_display;

   int checks = 0;
   int errors = 0;

   // mask bits: [0] expired, [1] one_hz_enable, [2] half_hz_enable, [3] value_display
   typedef struct {
      string      tag;
      logic [3:0] mask;
      logic       e_exp;
      logic       e_one;
      logic       e_half;
      logic [3:0] e_disp;
   } exp_t;

   typedef struct {
      logic       rst;
      logic       st;
      logic [3:0] val;
      logic [3:0] mask;
      logic       e_exp;
      logic       e_one;
      logic       e_half;
      logic [3:0] e_disp;
   } vec_t;

   exp_t sb_q[$];
   vec_t vecs[12];

   alarm_countdown_timer #(.CLK_HZ(CLK_HZ)) dut (
      .clock          (clock),
      .reset          (reset),
      .start_timer    (start_timer),
      .value          (value),
      .expired        (expired),
      .one_hz_enable  (one_hz_enable),
      .half_hz_enable (half_hz_enable),
      .value_display  (value_display)
   );

   always #5 clock = ~clock;

   task automatic check1(input string name, input logic [3:0] got, input logic [3:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
      end
   endtask

   // Drive one cycle of inputs, queue the expectation, compare after the edge
   task automatic step(input logic rst, input logic st, input logic [3:0] val, input exp_t e);
      exp_t x;
      reset       = rst;
      start_timer = st;
      value       = val;
      sb_q.push_back(e);
      @(posedge clock);
      #1;
      if (sb_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard: got empty queue expected an entry");
      end else begin
         x = sb_q.pop_front();
         if (x.mask[0]) check1({x.tag, ".expired"}, {3'd0, expired}, {3'd0, x.e_exp});
         if (x.mask[1]) check1({x.tag, ".one_hz"}, {3'd0, one_hz_enable}, {3'd0, x.e_one});
         if (x.mask[2]) check1({x.tag, ".half_hz"}, {3'd0, half_hz_enable}, {3'd0, x.e_half});
         if (x.mask[3]) check1({x.tag, ".display"}, value_display, x.e_disp);
      end
   endtask

   // Rising start at t=0 loads val; expectations follow from prescaler restart at the load edge
   task automatic run_load(input string tag, input int val, input int n, input bit hold);
      exp_t e;
      for (int t = 0; t < n; t++) begin
         e.tag    = $sformatf("%s.t%0d", tag, t);
         e.mask   = 4'b1011;
         e.e_exp  = (t >= val * CLK_HZ);
         e.e_one  = ((t % CLK_HZ) == CLK_HZ - 1);
         e.e_half = 1'b0;
         e.e_disp = ((t / CLK_HZ) >= val) ? 4'd0 : 4'(val - t / CLK_HZ);
         if (t == 0) step(1'b1, 1'b1, 4'(val), e);
         else        step(1'b1, hold, 4'($urandom_range(15)), e);
      end
   endtask

   initial begin
      exp_t e;
      reset       = 1'b0;
      start_timer = 1'b0;
      value       = 4'd7;

      vecs[0]  = '{1'b0, 1'b0, 4'd7, 4'b1111, 1'b0, 1'b0, 1'b0, 4'd0};
      vecs[1]  = '{1'b0, 1'b0, 4'd7, 4'b1111, 1'b0, 1'b0, 1'b0, 4'd0};
      vecs[2]  = '{1'b0, 1'b0, 4'd7, 4'b1111, 1'b0, 1'b0, 1'b0, 4'd0};
      vecs[3]  = '{1'b1, 1'b0, 4'd7, 4'b1111, 1'b0, 1'b0, 1'b0, 4'd7};
      vecs[4]  = '{1'b1, 1'b0, 4'd7, 4'b1111, 1'b0, 1'b0, 1'b0, 4'd7};
      vecs[5]  = '{1'b1, 1'b0, 4'd7, 4'b1111, 1'b0, 1'b1, 1'b0, 4'd7};
      vecs[6]  = '{1'b1, 1'b0, 4'd7, 4'b1111, 1'b0, 1'b0, 1'b1, 4'd7};
      vecs[7]  = '{1'b1, 1'b0, 4'd7, 4'b1111, 1'b0, 1'b0, 1'b1, 4'd7};
      vecs[8]  = '{1'b1, 1'b0, 4'd7, 4'b1111, 1'b0, 1'b0, 1'b1, 4'd7};
      vecs[9]  = '{1'b1, 1'b0, 4'd7, 4'b1111, 1'b0, 1'b1, 1'b1, 4'd7};
      vecs[10] = '{1'b1, 1'b0, 4'd7, 4'b1111, 1'b0, 1'b0, 1'b0, 4'd7};
      vecs[11] = '{1'b1, 1'b0, 4'd5, 4'b1111, 1'b0, 1'b0, 1'b0, 4'd5};

      for (int i = 0; i < 12; i++) begin
         e.tag    = $sformatf("idle.v%0d", i);
         e.mask   = vecs[i].mask;
         e.e_exp  = vecs[i].e_exp;
         e.e_one  = vecs[i].e_one;
         e.e_half = vecs[i].e_half;
         e.e_disp = vecs[i].e_disp;
         step(vecs[i].rst, vecs[i].st, vecs[i].val, e);
      end

      run_load("count3", 3, 16, 1'b0);
      run_load("zero", 0, 8, 1'b0);
      run_load("restart_a", 5, 6, 1'b0);
      run_load("restart_b", 2, 12, 1'b0);
      run_load("tie_a", 5, 4, 1'b0);
      run_load("tie_b", 3, 14, 1'b0);
      run_load("hold", 2, 40, 1'b1);

      e = '{"hold_release", 4'b1001, 1'b1, 1'b0, 1'b0, 4'd0};
      step(1'b1, 1'b0, 4'd0, e);

      run_load("abort", 9, 10, 1'b0);
      e = '{"abort_reset", 4'b1111, 1'b0, 1'b0, 1'b0, 4'd0};
      step(1'b0, 1'b0, 4'd9, e);
      for (int i = 0; i < 40; i++) begin
         e = '{$sformatf("post_reset.%0d", i), 4'b1001, 1'b0, 1'b0, 1'b0, 4'd9};
         step(1'b1, 1'b0, 4'd9, e);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
